// File: rtl/srm_controller.sv
// srm_controller: instruction register, decoder and sequencing FSM for the Simple RISC Machine datapath
module srm_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic        err,
  output logic [15:0] datapath_in,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop
);
  localparam logic [2:0] WAIT      = 3'd0;
  localparam logic [2:0] WRITE_IMM = 3'd1;
  localparam logic [2:0] GET_A     = 3'd2;
  localparam logic [2:0] GET_B     = 3'd3;
  localparam logic [2:0] ALU       = 3'd4;
  localparam logic [2:0] CMP_S     = 3'd5;
  localparam logic [2:0] WRITE_REG = 3'd6;
  logic [15:0] r_ir;
  logic [2:0]  r_state, w_next;
  logic        r_err;
  logic [1:0]  w_op;
  logic        w_mov_imm, w_mov_reg, w_alu, w_legal;
  always_comb begin
    w_op      = r_ir[12:11];
    w_mov_imm = r_ir[15:13] == 3'b110 && w_op == 2'b10;
    w_mov_reg = r_ir[15:13] == 3'b110 && w_op == 2'b00;
    w_alu     = r_ir[15:13] == 3'b101;
    w_legal   = w_mov_imm || w_mov_reg || w_alu;
    case (r_state)
      WAIT:    w_next = !s ? WAIT :
                        w_mov_imm ? WRITE_IMM :
                        (w_mov_reg || (w_alu && w_op == 2'b11)) ? GET_B :
                        w_alu ? GET_A : WAIT;
      GET_A:   w_next = GET_B;
      GET_B:   w_next = (w_alu && w_op == 2'b01) ? CMP_S : ALU;
      ALU:     w_next = WRITE_REG;
      default: w_next = WAIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WAIT;
      r_ir    <= 16'h0000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= r_state == WAIT && s && !w_legal;
      if (r_state == WAIT && load) r_ir <= in;
    end
  end
  always_comb begin
    w           = r_state == WAIT;
    err         = r_err;
    datapath_in = {{8{r_ir[7]}}, r_ir[7:0]};
    write       = !reset && (r_state == WRITE_IMM || r_state == WRITE_REG);
    loada       = !reset && r_state == GET_A;
    loadb       = !reset && r_state == GET_B;
    loadc       = !reset && r_state == ALU;
    loads       = !reset && r_state == CMP_S;
    asel        = r_state == ALU && (w_mov_reg || w_op == 2'b11);
    bsel        = 1'b0;
    vsel        = r_state == WRITE_IMM;
    shift       = (r_state == ALU || r_state == CMP_S) ? r_ir[4:3] : 2'b00;
    ALUop       = r_state == CMP_S ? 2'b01 : (r_state == ALU && !w_mov_reg) ? w_op : 2'b00;
    readnum     = r_state == GET_A ? r_ir[10:8] : r_state == GET_B ? r_ir[2:0] : 3'd0;
    writenum    = r_state == WRITE_IMM ? r_ir[10:8] : r_state == WRITE_REG ? r_ir[7:5] : 3'd0;
  end
endmodule

// File: tb/tb_srm_controller.sv
// tb_srm_controller: directed self-checking bench for srm_controller
module tb_srm_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in = 16'h0000;
  logic        load = 1'b0;
  logic        s = 1'b0;
  logic        w, err, write, loada, loadb, loadc, loads, asel, bsel, vsel;
  logic [15:0] datapath_in;
  logic [2:0]  writenum, readnum;
  logic [1:0]  shift, ALUop;
  logic [19:0] ctl;
  int errors = 0;
  int checks = 0;
  localparam logic [19:0] IDLE = {1'b1, 1'b0, 5'b00000, 3'b000, 2'b00, 2'b00, 3'd0, 3'd0};
  srm_controller dut (
    .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w), .err(err),
    .datapath_in(datapath_in), .writenum(writenum), .readnum(readnum),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop)
  );
  always #5 clk = ~clk;
  assign ctl = {w, err, write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, ALUop, readnum, writenum};
  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ex(input string tag, input logic [19:0] exp);
    chk(tag, ctl, exp);
    tick();
  endtask
  task automatic ld(input logic [15:0] v);
    in = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask
  task automatic go();
    s = 1'b1;
    tick();
    s = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("reset_ctl", ctl, IDLE);
    chk("reset_dp", {4'h0, datapath_in}, 20'h00000);
    ld(16'hD107);
    chk("d107_dp", {4'h0, datapath_in}, 20'h00007);
    go();
    ex("d107_wimm", {1'b0, 1'b0, 5'b10000, 3'b001, 2'b00, 2'b00, 3'd0, 3'd1});
    ex("d107_done", IDLE);
    ld(16'hD2FB);
    chk("d2fb_dp", {4'h0, datapath_in}, 20'h0FFFB);
    go();
    ex("d2fb_wimm", {1'b0, 1'b0, 5'b10000, 3'b001, 2'b00, 2'b00, 3'd0, 3'd2});
    ex("d2fb_done", IDLE);
    ld(16'hA148);
    go();
    ex("add_geta", {1'b0, 1'b0, 5'b01000, 3'b000, 2'b00, 2'b00, 3'd1, 3'd0});
    in = 16'hD105;
    load = 1'b1;
    s = 1'b1;
    ex("add_getb", {1'b0, 1'b0, 5'b00100, 3'b000, 2'b00, 2'b00, 3'd0, 3'd0});
    load = 1'b0;
    s = 1'b0;
    ex("add_alu", {1'b0, 1'b0, 5'b00010, 3'b000, 2'b01, 2'b00, 3'd0, 3'd0});
    ex("add_wreg", {1'b0, 1'b0, 5'b10000, 3'b000, 2'b00, 2'b00, 3'd0, 3'd2});
    chk("add_ir_kept", {4'h0, datapath_in}, 20'h00048);
    ex("add_done", IDLE);
    chk("busy_s_ignored", ctl, IDLE);
    go();
    ex("b2b_geta", {1'b0, 1'b0, 5'b01000, 3'b000, 2'b00, 2'b00, 3'd1, 3'd0});
    ex("b2b_getb", {1'b0, 1'b0, 5'b00100, 3'b000, 2'b00, 2'b00, 3'd0, 3'd0});
    reset = 1'b1;
    #1;
    ex("rst_alu_gated", {1'b0, 1'b0, 5'b00000, 3'b000, 2'b01, 2'b00, 3'd0, 3'd0});
    chk("rst_ctl", ctl, IDLE);
    chk("rst_dp", {4'h0, datapath_in}, 20'h00000);
    reset = 1'b0;
    tick();
    chk("rst_no_write", ctl, IDLE);
    ld(16'hA900);
    go();
    ex("cmp_geta", {1'b0, 1'b0, 5'b01000, 3'b000, 2'b00, 2'b00, 3'd1, 3'd0});
    ex("cmp_getb", {1'b0, 1'b0, 5'b00100, 3'b000, 2'b00, 2'b00, 3'd0, 3'd0});
    ex("cmp_s", {1'b0, 1'b0, 5'b00001, 3'b000, 2'b00, 2'b01, 3'd0, 3'd0});
    ex("cmp_done", IDLE);
    ld(16'hB860);
    go();
    ex("mvn_getb", {1'b0, 1'b0, 5'b00100, 3'b000, 2'b00, 2'b00, 3'd0, 3'd0});
    ex("mvn_alu", {1'b0, 1'b0, 5'b00010, 3'b100, 2'b00, 2'b11, 3'd0, 3'd0});
    ex("mvn_wreg", {1'b0, 1'b0, 5'b10000, 3'b000, 2'b00, 2'b00, 3'd0, 3'd3});
    ex("mvn_done", IDLE);
    ld(16'hC0BA);
    chk("movr_dp", {4'h0, datapath_in}, 20'h0FFBA);
    go();
    ex("movr_getb", {1'b0, 1'b0, 5'b00100, 3'b000, 2'b00, 2'b00, 3'd2, 3'd0});
    ex("movr_alu", {1'b0, 1'b0, 5'b00010, 3'b100, 2'b11, 2'b00, 3'd0, 3'd0});
    ex("movr_wreg", {1'b0, 1'b0, 5'b10000, 3'b000, 2'b00, 2'b00, 3'd0, 3'd5});
    ex("movr_done", IDLE);
    ld(16'h0000);
    go();
    ex("ill0_err", {1'b1, 1'b1, 5'b00000, 3'b000, 2'b00, 2'b00, 3'd0, 3'd0});
    ex("ill0_clear", IDLE);
    ld(16'hD800);
    go();
    ex("ill_d800_err", {1'b1, 1'b1, 5'b00000, 3'b000, 2'b00, 2'b00, 3'd0, 3'd0});
    ex("ill_d800_clear", IDLE);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
